// File: rtl/gcid_node_router.sv
// Maps {z,y,x} global cell IDs to owning FPGA node and steers records to local or remote outputs.
// Two-stage valid/ready pipeline: S1 decodes the node, S2 holds the steered record.
module gcid_node_router #(
  parameter int unsigned GCID_W        = 3,
  parameter int unsigned DATA_W        = 96,
  parameter int unsigned CPN_LOG2      = 1,
  parameter int unsigned X_NODES       = 2,
  parameter int unsigned Y_NODES       = 2,
  parameter int unsigned Z_NODES       = 2,
  parameter int unsigned NODE_ID_W     = 3,
  parameter int unsigned LOCAL_NODE_ID = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*GCID_W-1:0]    i_gcid,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_local_valid,
  output logic [3*GCID_W-1:0]    o_local_gcid,
  output logic [DATA_W-1:0]      o_local_data,
  input  logic                   i_local_ready,
  output logic                   o_remote_valid,
  output logic [NODE_ID_W-1:0]   o_remote_node_id,
  output logic [3*GCID_W-1:0]    o_remote_gcid,
  output logic [DATA_W-1:0]      o_remote_data,
  input  logic                   i_remote_ready,
  input  logic                   i_clr_cnt,
  output logic [CNT_W-1:0]       o_local_cnt,
  output logic [CNT_W-1:0]       o_remote_cnt,
  output logic                   o_err_range
);

  localparam int unsigned GID_W = 3 * GCID_W;

  logic                 s1_full;
  logic [GID_W-1:0]     s1_gcid;
  logic [DATA_W-1:0]    s1_data;
  logic [GID_W-1:0]     s2_gcid;
  logic [DATA_W-1:0]    s2_data;
  logic [NODE_ID_W-1:0] s2_node_id;

  logic [31:0]          nx_c, ny_c, nz_c;
  logic                 range_err_c;
  logic [NODE_ID_W-1:0] node_id_c;
  logic                 is_local_c;
  logic                 local_hs_c, remote_hs_c;
  logic                 s2_drain_c, s2_free_c;
  logic                 s1_advance_c, s1_load_c, s2_load_c;

  // S1 decode: node coordinates, grid range check, linear node ID
  always_comb begin
    nx_c        = 32'(s1_gcid[GCID_W-1:0]) >> CPN_LOG2;
    ny_c        = 32'(s1_gcid[2*GCID_W-1:GCID_W]) >> CPN_LOG2;
    nz_c        = 32'(s1_gcid[3*GCID_W-1:2*GCID_W]) >> CPN_LOG2;
    range_err_c = (nx_c >= X_NODES) | (ny_c >= Y_NODES) | (nz_c >= Z_NODES);
    node_id_c   = NODE_ID_W'(nz_c * X_NODES * Y_NODES + ny_c * X_NODES + nx_c);
    is_local_c  = (node_id_c == NODE_ID_W'(LOCAL_NODE_ID));
  end

  // Flow control: errored records leave S1 without needing room in S2
  always_comb begin
    local_hs_c   = o_local_valid & i_local_ready;
    remote_hs_c  = o_remote_valid & i_remote_ready;
    s2_drain_c   = local_hs_c | remote_hs_c;
    s2_free_c    = ~(o_local_valid | o_remote_valid) | s2_drain_c;
    s1_advance_c = s1_full & (range_err_c | s2_free_c);
    o_ready      = ~s1_full | s1_advance_c;
    s1_load_c    = i_valid & o_ready;
    s2_load_c    = s1_advance_c & ~range_err_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_gcid <= '0;
      s1_data <= '0;
    end else if (s1_load_c) begin
      s1_full <= 1'b1;
      s1_gcid <= i_gcid;
      s1_data <= i_data;
    end else if (s1_advance_c) begin
      s1_full <= 1'b0;
    end
  end

  // S2 holds one steered record; exactly one output valid while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_local_valid  <= 1'b0;
      o_remote_valid <= 1'b0;
      s2_node_id     <= '0;
      s2_gcid        <= '0;
      s2_data        <= '0;
    end else if (s2_load_c) begin
      o_local_valid  <= is_local_c;
      o_remote_valid <= ~is_local_c;
      s2_node_id     <= node_id_c;
      s2_gcid        <= s1_gcid;
      s2_data        <= s1_data;
    end else if (s2_drain_c) begin
      o_local_valid  <= 1'b0;
      o_remote_valid <= 1'b0;
    end
  end

  assign o_local_gcid     = s2_gcid;
  assign o_local_data     = s2_data;
  assign o_remote_gcid    = s2_gcid;
  assign o_remote_data    = s2_data;
  assign o_remote_node_id = s2_node_id;

  // Saturating statistics and sticky range error; clear wins over same-cycle updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_local_cnt  <= '0;
      o_remote_cnt <= '0;
      o_err_range  <= 1'b0;
    end else if (i_clr_cnt) begin
      o_local_cnt  <= '0;
      o_remote_cnt <= '0;
      o_err_range  <= 1'b0;
    end else begin
      if (local_hs_c && (o_local_cnt != '1)) o_local_cnt <= o_local_cnt + CNT_W'(1);
      if (remote_hs_c && (o_remote_cnt != '1)) o_remote_cnt <= o_remote_cnt + CNT_W'(1);
      if (s1_advance_c && range_err_c) o_err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcid_node_router.sv
// Scoreboard bench for gcid_node_router: stimulus pushes expected records, a monitor pops on each output handshake.
module tb_gcid_node_router;

  localparam int unsigned GCID_W    = 3;
  localparam int unsigned GID_W     = 9;
  localparam int unsigned DATA_W    = 96;
  localparam int unsigned NODE_ID_W = 3;
  localparam int unsigned CNT_W     = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [GID_W-1:0]     i_gcid;
  logic [DATA_W-1:0]    i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_local_valid;
  logic [GID_W-1:0]     o_local_gcid;
  logic [DATA_W-1:0]    o_local_data;
  logic                 i_local_ready;
  logic                 o_remote_valid;
  logic [NODE_ID_W-1:0] o_remote_node_id;
  logic [GID_W-1:0]     o_remote_gcid;
  logic [DATA_W-1:0]    o_remote_data;
  logic                 i_remote_ready;
  logic                 i_clr_cnt;
  logic [CNT_W-1:0]     o_local_cnt;
  logic [CNT_W-1:0]     o_remote_cnt;
  logic                 o_err_range;

  gcid_node_router #(.GCID_W(GCID_W), .DATA_W(DATA_W), .NODE_ID_W(NODE_ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_gcid(i_gcid), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_local_valid(o_local_valid), .o_local_gcid(o_local_gcid), .o_local_data(o_local_data),
    .i_local_ready(i_local_ready),
    .o_remote_valid(o_remote_valid), .o_remote_node_id(o_remote_node_id),
    .o_remote_gcid(o_remote_gcid), .o_remote_data(o_remote_data), .i_remote_ready(i_remote_ready),
    .i_clr_cnt(i_clr_cnt), .o_local_cnt(o_local_cnt), .o_remote_cnt(o_remote_cnt),
    .o_err_range(o_err_range)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 is_local;
    logic [NODE_ID_W-1:0] node;
    logic [GID_W-1:0]     gcid;
    logic [DATA_W-1:0]    data;
  } exp_t;

  typedef struct packed {
    logic [GID_W-1:0]  gcid;
    logic [DATA_W-1:0] data;
    logic              is_local;
    logic [2:0]        node;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one-hot valids, stability under stall, in-order scoreboard compare
  logic         stall_prev = 1'b0;
  logic [214:0] snap_prev;
  logic [214:0] snap_now;
  exp_t         e;

  always @(negedge clk) begin
    snap_now = {o_local_valid, o_remote_valid, o_remote_node_id, o_local_gcid, o_remote_gcid,
                o_local_data, o_remote_data};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (o_local_valid || o_remote_valid)
        check("one_valid", 256'(o_local_valid & o_remote_valid), 256'(0));
      if (stall_prev) check("stable_under_stall", 256'(snap_now), 256'(snap_prev));
      if ((o_local_valid && i_local_ready) || (o_remote_valid && i_remote_ready)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got gcid %0h with empty scoreboard",
                   o_local_valid ? o_local_gcid : o_remote_gcid);
        end else begin
          e = sb.pop_front();
          check("out_is_local", 256'(o_local_valid), 256'(e.is_local));
          if (o_local_valid) begin
            check("local_gcid", 256'(o_local_gcid), 256'(e.gcid));
            check("local_data", 256'(o_local_data), 256'(e.data));
          end else begin
            check("remote_node", 256'(o_remote_node_id), 256'(e.node));
            check("remote_gcid", 256'(o_remote_gcid), 256'(e.gcid));
            check("remote_data", 256'(o_remote_data), 256'(e.data));
          end
        end
        hs_cyc.push_back(cyc);
        stall_prev = 1'b0;
      end else begin
        stall_prev = o_local_valid | o_remote_valid;
      end
      snap_prev = snap_now;
    end
  end

  // Drive one record; returns number of cycles it waited for o_ready
  task automatic send(input vec_t v, input bit push, output int waits);
    logic acc;
    bit   done;
    done   = 1'b0;
    waits  = 0;
    i_valid = 1'b1;
    i_gcid  = v.gcid;
    i_data  = v.data;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
      else waits++;
    end
    i_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept for gcid %0h expected accept within 200 cycles", v.gcid);
    end else if (push) begin
      sb.push_back({v.is_local, v.node, v.gcid, v.data});
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !o_local_valid && !o_remote_valid) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic clr_pulse();
    i_clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    i_clr_cnt = 1'b0;
  endtask

  // {z,y,x} in octal; CPN_LOG2=1 on a 2x2x2 grid: node = (z>>1)*4 + (y>>1)*2 + (x>>1)
  vec_t burst[8] = '{
    '{9'o000, 96'h10, 1'b1, 3'd0},
    '{9'o002, 96'h11, 1'b0, 3'd1},
    '{9'o020, 96'h12, 1'b0, 3'd2},
    '{9'o033, 96'h13, 1'b0, 3'd3},
    '{9'o301, 96'h14, 1'b0, 3'd4},
    '{9'o222, 96'h15, 1'b0, 3'd7},
    '{9'o111, 96'h16, 1'b1, 3'd0},
    '{9'o230, 96'h17, 1'b0, 3'd6}
  };

  int w;
  int wsum;
  int hs0;

  initial begin
    rst_n = 1'b1;
    i_gcid = '0; i_data = '0; i_valid = 1'b0;
    i_local_ready = 1'b1; i_remote_ready = 1'b1; i_clr_cnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_local_valid", 256'(o_local_valid), 256'(0));
    check("rst_remote_valid", 256'(o_remote_valid), 256'(0));
    check("rst_cnts", 256'({o_local_cnt, o_remote_cnt}), 256'(0));
    check("rst_err", 256'(o_err_range), 256'(0));
    check("rst_ready", 256'(o_ready), 256'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Local record: x=1,y=1,z=0 -> node 0
    send('{9'o011, 96'hA5, 1'b1, 3'd0}, 1'b1, w);
    check("lat_s1_only", 256'(o_local_valid), 256'(0));
    @(posedge clk);
    #1;
    check("lat_local_valid", 256'(o_local_valid), 256'(1));
    check("lat_local_data", 256'(o_local_data), 256'(96'hA5));
    wait_drain();
    check("local_cnt_1", 256'(o_local_cnt), 256'(1));

    // Remote record: x=3,y=0,z=2 -> node 5
    send('{9'o203, 96'h5A, 1'b0, 3'd5}, 1'b1, w);
    @(posedge clk);
    #1;
    check("remote_valid", 256'(o_remote_valid), 256'(1));
    check("remote_node_5", 256'(o_remote_node_id), 256'(5));
    wait_drain();
    check("remote_cnt_1", 256'(o_remote_cnt), 256'(1));

    // Back-to-back mixed burst, no bubbles in or out
    wsum = 0;
    hs0 = hs_cyc.size();
    for (int i = 0; i < 8; i++) begin
      send(burst[i], 1'b1, w);
      wsum += w;
    end
    wait_drain();
    check("burst_no_input_stall", 256'(wsum), 256'(0));
    check("burst_count", 256'(hs_cyc.size() - hs0), 256'(8));
    if (hs_cyc.size() - hs0 == 8)
      check("burst_no_bubbles", 256'(hs_cyc[hs0 + 7] - hs_cyc[hs0]), 256'(7));
    check("cnts_after_burst", 256'({o_local_cnt, o_remote_cnt}), 256'({6'd3, 6'd7}));

    // Remote stall with local ready high: S1 fills, o_ready drops
    i_remote_ready = 1'b0;
    send('{9'o003, 96'h21, 1'b0, 3'd1}, 1'b1, w);
    send('{9'o000, 96'h22, 1'b1, 3'd0}, 1'b1, w);
    check("stall_second_accepted", 256'(w), 256'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready_low", 256'(o_ready), 256'(0));
      check("stall_remote_held", 256'({o_remote_valid, o_remote_node_id}), 256'({1'b1, 3'd1}));
      @(posedge clk);
      #1;
    end
    i_remote_ready = 1'b1;
    send('{9'o033, 96'h23, 1'b0, 3'd3}, 1'b1, w);
    wait_drain();
    check("cnts_after_stall", 256'({o_local_cnt, o_remote_cnt}), 256'({6'd4, 6'd9}));

    // Out-of-grid x=5 is dropped; following record still flows
    send('{9'o005, 96'hEE, 1'b0, 3'd0}, 1'b0, w);
    send('{9'o011, 96'h31, 1'b1, 3'd0}, 1'b1, w);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 256'(o_err_range), 256'(1));
    check("cnts_after_err", 256'({o_local_cnt, o_remote_cnt}), 256'({6'd5, 6'd9}));
    clr_pulse();
    check("clr_err", 256'(o_err_range), 256'(0));
    check("clr_cnts", 256'({o_local_cnt, o_remote_cnt}), 256'(0));

    // Saturation: 66 local handshakes on a 6-bit counter
    for (int i = 0; i < 66; i++) send('{9'o001, 96'(i), 1'b1, 3'd0}, 1'b1, w);
    wait_drain();
    check("local_cnt_saturated", 256'(o_local_cnt), 256'(6'h3F));

    // Asynchronous reset with S1 and S2 both full
    i_local_ready = 1'b0;
    send('{9'o000, 96'h41, 1'b1, 3'd0}, 1'b1, w);
    send('{9'o000, 96'h42, 1'b1, 3'd0}, 1'b1, w);
    @(posedge clk);
    #2;
    check("pre_rst_full", 256'({o_local_valid, o_ready}), 256'({1'b1, 1'b0}));
    rst_n = 1'b0;
    #1;
    check("async_rst_valids", 256'({o_local_valid, o_remote_valid}), 256'(0));
    check("async_rst_cnts", 256'({o_local_cnt, o_remote_cnt}), 256'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_local_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 256'({o_local_valid, o_remote_valid, o_ready}), 256'({1'b0, 1'b0, 1'b1}));
    send('{9'o111, 96'h51, 1'b1, 3'd0}, 1'b1, w);
    wait_drain();
    check("post_rst_cnt", 256'(o_local_cnt), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
